// File: rtl/br_resolve.sv
// LC-3 BR resolver: latches IR/PC on start, waits out pending N/Z/P writes,
// then registers BEN/taken/target. Optional stats counters: BR_RESOLVE_STATS_EN.
module br_resolve #(
  parameter int WIDTH       = 16,
  parameter int OFFSET_BITS = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] ir,
  input  logic [WIDTH-1:0] pc,
  input  logic             n,
  input  logic             z,
  input  logic             p,
  input  logic             flag_busy,
  output logic             busy,
  output logic             done,
  output logic             ben,
  output logic             taken,
  output logic             not_br,
  output logic [WIDTH-1:0] target
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [15:0]      resolved_count,
  output logic [15:0]      taken_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FLAGS = 2'd1,
    S_EVAL       = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_pc;
  logic             r_ben;
  logic             r_taken;
  logic             r_not_br;
  logic [WIDTH-1:0] r_target;

  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_sext;
  logic             w_ben;
  logic             w_is_br;
  logic             w_taken;
  logic [WIDTH-1:0] w_target;

  // Flags are read live; only the EVAL cycle commits them, so any write
  // pending at start has landed by then.
  assign w_sext   = {{(WIDTH-OFFSET_BITS){r_ir[OFFSET_BITS-1]}}, r_ir[OFFSET_BITS-1:0]};
  assign w_ben    = |(r_ir[11:9] & {n, z, p});
  assign w_is_br  = (r_ir[WIDTH-1 -: 4] == 4'b0000);
  assign w_taken  = w_ben & w_is_br;
  assign w_target = w_taken ? (r_pc + w_sext) : r_pc;

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = flag_busy ? S_WAIT_FLAGS : S_EVAL;
      end
      S_WAIT_FLAGS: if (!flag_busy) w_next = S_EVAL;
      S_EVAL:       w_next = S_DONE;
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ir     <= '0;
      r_pc     <= '0;
      r_ben    <= 1'b0;
      r_taken  <= 1'b0;
      r_not_br <= 1'b0;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_ir <= ir;
        r_pc <= pc;
      end
      if (r_state == S_EVAL) begin
        r_ben    <= w_ben;
        r_taken  <= w_taken;
        r_not_br <= ~w_is_br;
        r_target <= w_target;
      end
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  logic [15:0] r_resolved_count;
  logic [15:0] r_taken_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resolved_count <= '0;
      r_taken_count    <= '0;
    end else if (r_state == S_EVAL) begin
      r_resolved_count <= r_resolved_count + 16'd1;
      if (w_taken) r_taken_count <= r_taken_count + 16'd1;
    end
  end

  assign resolved_count = r_resolved_count;
  assign taken_count    = r_taken_count;
`endif

  assign busy   = w_busy;
  assign done   = w_done;
  assign ben    = r_ben;
  assign taken  = r_taken;
  assign not_br = r_not_br;
  assign target = r_target;

endmodule

// File: tb/tb_br_resolve.sv
// Scoreboard bench for br_resolve: expected results queued at start, popped at done.
module tb_br_resolve;

  typedef struct packed {
    logic        ben;
    logic        taken;
    logic        not_br;
    logic [15:0] target;
  } res_t;

  logic        clk = 1'b0;
  logic        reset, start, n, z, p, flag_busy;
  logic [15:0] ir, pc;
  logic        busy, done, ben, taken, not_br;
  logic [15:0] target;
`ifdef BR_RESOLVE_STATS_EN
  logic [15:0] resolved_count, taken_count;
`endif

  int   vectors = 0;
  int   errors  = 0;
  res_t sbq[$];

  always #5 clk = ~clk;

  br_resolve #(.WIDTH(16), .OFFSET_BITS(9)) dut (
    .clk(clk), .reset(reset), .start(start), .ir(ir), .pc(pc),
    .n(n), .z(z), .p(p), .flag_busy(flag_busy),
    .busy(busy), .done(done), .ben(ben), .taken(taken), .not_br(not_br),
    .target(target)
`ifdef BR_RESOLVE_STATS_EN
    , .resolved_count(resolved_count), .taken_count(taken_count)
`endif
  );

  function automatic res_t model(logic [15:0] i, logic [15:0] pcv, logic fn, logic fz, logic fp);
    res_t e;
    e.ben    = (i[11] & fn) | (i[10] & fz) | (i[9] & fp);
    e.not_br = (i[15:12] != 4'h0);
    e.taken  = e.ben & ~e.not_br;
    e.target = e.taken ? pcv + {{7{i[8]}}, i[8:0]} : pcv;
    return e;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Steps until done is seen; lat counts edges since the start edge, -1 on timeout.
  task automatic wait_done(input int base, output int lat);
    lat = base;
    do begin
      step();
      lat++;
      start = 1'b0;
    end while (done !== 1'b1 && lat < 30);
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic launch(input logic [15:0] i, input logic [15:0] pcv, input logic fb);
    ir = i; pc = pcv; flag_busy = fb; start = 1'b1;
  endtask

  task automatic test_reset();
    res_t got;
    reset = 1'b1; start = 1'b0; ir = 16'hFFFF; pc = 16'hFFFF;
    n = 1'b0; z = 1'b0; p = 1'b0; flag_busy = 1'b0;
    step(); step();
    got = '{ben, taken, not_br, target};
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || got !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b res=%h want 0", busy, done, got);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_always_taken();
    int lat; res_t e, got;
    {n, z, p} = 3'b010;
    launch(16'h0E05, 16'h3001, 1'b0);
    sbq.push_back('{1'b1, 1'b1, 1'b0, 16'h3006});
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL taken_idle_busy: got %b want 0", busy); end
    wait_done(0, lat);
    vectors++;
    if (lat !== 2) begin errors++; $display("FAIL taken_latency: got %0d want 2", lat); end
    e = sbq.pop_front(); got = '{ben, taken, not_br, target};
    vectors++;
    if (got !== e) begin errors++; $display("FAIL taken_result: got %h want %h", got, e); end
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL done_busy: got %b want 1", busy); end
    step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || target !== 16'h3006) begin
      errors++;
      $display("FAIL done_pulse_hold: done=%b busy=%b target=%h want 0 0 3006", done, busy, target);
    end
  endtask

  task automatic test_negative_offset();
    int lat; res_t e, got;
    logic [2:0] flg [2] = '{3'b001, 3'b010};
    res_t       want[2] = '{'{1'b1, 1'b1, 1'b0, 16'h3000}, '{1'b0, 1'b0, 1'b0, 16'h3001}};
    for (int k = 0; k < 2; k++) begin
      {n, z, p} = flg[k];
      launch(16'h0BFF, 16'h3001, 1'b0);
      sbq.push_back(want[k]);
      wait_done(0, lat);
      e = sbq.pop_front(); got = '{ben, taken, not_br, target};
      vectors++;
      if (lat !== 2 || got !== e) begin
        errors++;
        $display("FAIL neg_offset_%0d: lat=%0d got %h want lat=2 %h", k, lat, got, e);
      end
      step();
    end
  endtask

  task automatic test_nzp_fields();
    int lat; res_t e, got;
    logic [15:0] irs [2] = '{16'h0005, 16'h0E05};
    logic [2:0]  flg [2] = '{3'b111, 3'b000};
    for (int k = 0; k < 2; k++) begin
      {n, z, p} = flg[k];
      launch(irs[k], 16'h1000, 1'b0);
      sbq.push_back('{1'b0, 1'b0, 1'b0, 16'h1000});
      wait_done(0, lat);
      e = sbq.pop_front(); got = '{ben, taken, not_br, target};
      vectors++;
      if (lat !== 2 || got !== e) begin
        errors++;
        $display("FAIL nzp_never_%0d: lat=%0d got %h want lat=2 %h", k, lat, got, e);
      end
      step();
    end
  endtask

  task automatic test_flag_stall();
    int lat; res_t e, got;
    {n, z, p} = 3'b010;
    launch(16'h0805, 16'h3001, 1'b1);
    sbq.push_back('{1'b1, 1'b1, 1'b0, 16'h3006});
    step(); start = 1'b0; {n, z, p} = 3'b100;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL stall_wait: busy=%b done=%b want 1 0", busy, done);
    end
    step(); flag_busy = 1'b0;
    wait_done(2, lat);
    vectors++;
    if (lat !== 4) begin errors++; $display("FAIL stall_latency: got %0d want 4", lat); end
    e = sbq.pop_front(); got = '{ben, taken, not_br, target};
    vectors++;
    if (got !== e) begin errors++; $display("FAIL stall_result: got %h want %h", got, e); end
    step();
  endtask

  task automatic test_wrap();
    int lat; res_t e, got;
    {n, z, p} = 3'b001;
    launch(16'h0202, 16'hFFFF, 1'b0);
    sbq.push_back('{1'b1, 1'b1, 1'b0, 16'h0001});
    wait_done(0, lat);
    e = sbq.pop_front(); got = '{ben, taken, not_br, target};
    vectors++;
    if (lat !== 2 || got !== e) begin
      errors++; $display("FAIL wrap: lat=%0d got %h want lat=2 %h", lat, got, e);
    end
    step();
  endtask

  task automatic test_non_br_ignored_start();
    int lat, pulses; res_t e, got;
`ifdef BR_RESOLVE_STATS_EN
    logic [15:0] rc0;
    rc0 = resolved_count;
`endif
    {n, z, p} = 3'b010;
    launch(16'h1E05, 16'h4000, 1'b0);
    sbq.push_back('{1'b1, 1'b0, 1'b1, 16'h4000});
    step();
    ir = 16'h0E05; pc = 16'h1234; start = 1'b1;
    wait_done(1, lat);
    e = sbq.pop_front(); got = '{ben, taken, not_br, target};
    vectors++;
    if (lat !== 2 || got !== e) begin
      errors++; $display("FAIL non_br: lat=%0d got %h want lat=2 %h", lat, got, e);
    end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin errors++; $display("FAIL ignored_start_pulses: got %0d want 0", pulses); end
`ifdef BR_RESOLVE_STATS_EN
    vectors++;
    if (resolved_count !== rc0 + 16'd1) begin
      errors++; $display("FAIL stats_resolved: got %0d want %0d", resolved_count, rc0 + 16'd1);
    end
`endif
  endtask

  task automatic test_random();
    int lat, exp_tk; res_t e, got; logic [15:0] i;
`ifdef BR_RESOLVE_STATS_EN
    logic [15:0] tk0;
    tk0 = taken_count;
`endif
    exp_tk = 0;
    for (int k = 0; k < 24; k++) begin
      i = 16'($urandom);
      if (k % 3 != 0) i[15:12] = 4'h0;
      {n, z, p} = 3'($urandom);
      launch(i, 16'($urandom), 1'b0);
      sbq.push_back(model(i, pc, n, z, p));
      wait_done(0, lat);
      e = sbq.pop_front(); got = '{ben, taken, not_br, target};
      if (e.taken) exp_tk++;
      vectors++;
      if (lat !== 2 || got !== e) begin
        errors++; $display("FAIL random_%0d ir=%h: lat=%0d got %h want lat=2 %h", k, i, lat, got, e);
      end
      step();
    end
`ifdef BR_RESOLVE_STATS_EN
    vectors++;
    if (taken_count !== tk0 + 16'(exp_tk)) begin
      errors++; $display("FAIL stats_taken: got %0d want %0d", taken_count, tk0 + 16'(exp_tk));
    end
`endif
  endtask

  task automatic test_reset_in_wait();
    int pulses; res_t got;
    {n, z, p} = 3'b001;
    launch(16'h0202, 16'h2000, 1'b1);
    step(); start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; flag_busy = 1'b0;
    got = '{ben, taken, not_br, target};
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || got !== '0) begin
      errors++; $display("FAIL reset_wait: busy=%b done=%b res=%h want 0 0 0", busy, done, got);
    end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin errors++; $display("FAIL reset_wait_pulses: got %0d want 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_always_taken();
    test_negative_offset();
    test_nzp_fields();
    test_flag_stall();
    test_wrap();
    test_non_br_ignored_start();
    test_random();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/br_resolve.md
Name: br_resolve

Overview:
- Consumer side of the LC-3 condition-code register: evaluates BR instructions against the latched N/Z/P flags.
- Latches a BR instruction and the incremented PC on a start handshake.
- Waits out any in-flight flag write, then computes BEN and the branch target PC+SEXT(PCoffset9).
- Presents the registered result to the control FSM with a one-cycle done pulse.

Parameters:
- WIDTH, 16, datapath width of PC, IR and target (LC-3 fixed at 16).
- OFFSET_BITS, 9, width of the PC offset field IR[OFFSET_BITS-1:0], sign-extended to WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to resolve; sampled only in IDLE.
- ir  input  WIDTH  instruction word, sampled with start.
- pc  input  WIDTH  already-incremented PC, sampled with start.
- n  input  1  N flag from the condition-code register.
- z  input  1  Z flag from the condition-code register.
- p  input  1  P flag from the condition-code register.
- flag_busy  input  1  high while a flag write is pending this cycle (the flag write-enable).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- ben  output  1  registered branch-enable: |(IR[11:9] & {n,z,p}).
- taken  output  1  ben AND opcode is BR (IR[15:12]==4'b0000).
- not_br  output  1  latched opcode was not BR.
- target  output  WIDTH  taken ? pc+SEXT(offset) : pc.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, ben=0, taken=0, not_br=0, target=0; internal ir/pc latches cleared.
- States: IDLE, WAIT_FLAGS, EVAL, DONE.
- IDLE:
  - On start=1, latch ir and pc.
  - Next state is WAIT_FLAGS if flag_busy=1, else EVAL.
  - start=0 keeps the block in IDLE.
- WAIT_FLAGS: stay while flag_busy=1; go to EVAL when flag_busy=0.
- EVAL:
  - Sample n,z,p in this cycle only.
  - Register ben, taken, not_br and target; go to DONE.
- DONE: done=1 for exactly one cycle; next state is IDLE.
- Latency: start to done is 2 cycles when flag_busy=0, plus one cycle per flag_busy cycle.
- start while busy=1 is ignored; there is no queueing.
- Result outputs hold their value until the next EVAL or a reset.
- Arithmetic:
  - target = pc + SEXT(IR[OFFSET_BITS-1:0]), computed modulo 2^WIDTH.
  - Wrap-around in either direction is legal and silent.
- nzp field 000 is never taken. nzp field 111 is always taken when any flag is set.
- Flag combination 000 (illegal) matches nothing, so ben=0.
- Non-BR opcode: not_br=1, ben is still computed from IR[11:9], taken=0, target=pc.
- Simultaneous start and flag_busy in IDLE: go to WAIT_FLAGS; the pre-write flags are never used.
- Reset in any state forces IDLE on the next edge, clears all outputs, and suppresses any pending done.
- done and busy are both high in DONE.

Optional Feature:
- Macro: BR_RESOLVE_STATS_EN.
- When defined, two extra outputs are added:
  - resolved_count [15:0]: increments in every EVAL cycle.
  - taken_count [15:0]: increments in EVAL when taken is being set to 1.
  - Both counters reset to 0 and wrap at 16'hFFFF to 0.
- When not defined, the ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Always-taken, no stall:
  - Stimulus: flags N=0,Z=1,P=0, flag_busy=0, start with ir=16'h0E05 (BRnzp +5), pc=16'h3001.
  - Response: done at cycle+2; ben=1, taken=1, target=16'h3006, not_br=0.
- Negative offset:
  - Stimulus: ir=16'h0BFF (BRnp -1), pc=16'h3001.
  - Response with P=1: taken=1, target=16'h3000.
  - Response with Z=1: taken=0, target=16'h3001.
- Flag stall:
  - Stimulus: start with flag_busy=1 held for 2 cycles, flags change Z->N during the stall, ir=16'h0805 (BRn).
  - Response: done at cycle+4, taken=1 (the post-write flags were used).
- Wrap-around:
  - Stimulus: pc=16'hFFFF, ir=16'h0202 (BRp +2), P=1.
  - Response: target=16'h0001, taken=1.
- Non-BR and ignored start:
  - Stimulus: ir=16'h1E05 (ADD), a second start asserted while busy.
  - Response: not_br=1, taken=0, target=pc; only one done pulse.
  - Stats build: resolved_count increments by exactly 1.
- Reset in WAIT_FLAGS:
  - Stimulus: assert reset while in WAIT_FLAGS.
  - Response: next cycle busy=0, done=0, taken=0, target=0; no done pulse follows.
